// File: rtl/clock_set_ctrl.sv
// ----------------------------------------------------------------------------
// clock_set_ctrl
// Time-set controller for the 12 h binary/7-seg clock. Walks the edit modes
// RUN -> SET_HRS -> SET_MINS (-> SET_AHRS -> SET_AMINS) -> RUN on mode presses,
// issues one-cycle increment pulses for the field being edited (with
// auto-repeat while up is held), freezes the seconds counter during a set
// session, requests a seconds clear when a modified session ends, and drives a
// blink blanking mask for the seg7 driver.
//
// Optional feature macro: ALARM_SET_EN (adds the alarm-hours/minutes set states
// and drives inc_alm_*_p; without it those ports are tied low).
//
// Ports
//   clk_100MHz      in   system clock
//   reset           in   synchronous, active-high reset
//   btn_mode        in   debounced mode button (level)
//   btn_up          in   debounced increment button (level)
//   inc_hrs_p       out  one-cycle hours increment pulse
//   inc_mins_p      out  one-cycle minutes increment pulse
//   inc_alm_hrs_p   out  one-cycle alarm-hours increment pulse
//   inc_alm_mins_p  out  one-cycle alarm-minutes increment pulse
//   clr_secs_p      out  one-cycle seconds clear on exit of a modified session
//   run_en          out  1 = seconds counter may advance
//   blank_mask      out  per-digit blank (1 = off), [3:2] hours, [1:0] minutes
//   mode            out  0 RUN, 1 SET_HRS, 2 SET_MINS, 3 SET_AHRS, 4 SET_AMINS
// ----------------------------------------------------------------------------
module clock_set_ctrl #(
    parameter int unsigned HOLD_CYC    = 50_000_000,
    parameter int unsigned REPEAT_CYC  = 10_000_000,
    parameter int unsigned BLINK_CYC   = 25_000_000,
    parameter int unsigned TIMEOUT_CYC = 1_000_000_000
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    output logic       inc_hrs_p,
    output logic       inc_mins_p,
    output logic       inc_alm_hrs_p,
    output logic       inc_alm_mins_p,
    output logic       clr_secs_p,
    output logic       run_en,
    output logic [3:0] blank_mask,
    output logic [2:0] mode
);

    localparam int unsigned HOLD_W  = $clog2(HOLD_CYC + 1);
    localparam int unsigned BLINK_W = $clog2(BLINK_CYC + 1);
    localparam int unsigned IDLE_W  = $clog2(TIMEOUT_CYC + 1);
    // After each repeat the hold counter is rewound so that it reaches
    // HOLD_CYC again REPEAT_CYC cycles later (needs REPEAT_CYC <= HOLD_CYC).
    localparam int unsigned RELOAD_CYC = HOLD_CYC - REPEAT_CYC;

    localparam logic [2:0] ST_RUN       = 3'd0;
    localparam logic [2:0] ST_SET_HRS   = 3'd1;
    localparam logic [2:0] ST_SET_MINS  = 3'd2;
    localparam logic [2:0] ST_SET_AHRS  = 3'd3;
    localparam logic [2:0] ST_SET_AMINS = 3'd4;

    // State and datapath registers
    logic [2:0]         state,     state_nx;
    logic               btn_mode_prev, btn_up_prev;
    logic               up_active, up_active_nx;
    logic [HOLD_W-1:0]  hold_cnt,  hold_nx;
    logic [IDLE_W-1:0]  idle_cnt,  idle_nx;
    logic [BLINK_W-1:0] blink_cnt, blink_cnt_nx;
    logic               blink_ph,  blink_ph_nx;
    logic               dirty,     dirty_nx;

    // Next values of the registered outputs
    logic               inc_hrs_nx, inc_mins_nx, clr_secs_nx, run_en_nx;
    logic [3:0]         blank_nx;
`ifdef ALARM_SET_EN
    logic               inc_alm_hrs_nx, inc_alm_mins_nx;
`endif

    // Combinational helpers
    logic               rise_mode, rise_up, in_set, fire;
    logic [HOLD_W-1:0]  hold_inc;
    logic [IDLE_W-1:0]  idle_inc;
    logic [BLINK_W-1:0] blink_inc;

    assign rise_mode = btn_mode & ~btn_mode_prev;
    assign rise_up   = btn_up & ~btn_up_prev;
    assign in_set    = (state != ST_RUN);
    assign hold_inc  = hold_cnt + HOLD_W'(1);
    assign idle_inc  = idle_cnt + IDLE_W'(1);
    assign blink_inc = blink_cnt + BLINK_W'(1);

    assign mode = state;

    // Next-state, counters and output decode
    always_comb begin
        state_nx     = state;
        up_active_nx = up_active;
        hold_nx      = hold_cnt;
        idle_nx      = idle_cnt;
        blink_cnt_nx = blink_cnt;
        blink_ph_nx  = blink_ph;
        dirty_nx     = dirty;
        fire         = 1'b0;
        inc_hrs_nx   = 1'b0;
        inc_mins_nx  = 1'b0;
`ifdef ALARM_SET_EN
        inc_alm_hrs_nx  = 1'b0;
        inc_alm_mins_nx = 1'b0;
`endif
        clr_secs_nx  = 1'b0;
        run_en_nx    = 1'b1;
        blank_nx     = 4'b0000;

        // Mode press wins over a same-cycle up press and cancels any repeat;
        // up must then be released and pressed again to edit.
        if (rise_mode) begin
            up_active_nx = 1'b0;
            hold_nx      = '0;
            case (state)
                ST_RUN:      state_nx = ST_SET_HRS;
                ST_SET_HRS:  state_nx = ST_SET_MINS;
                ST_SET_MINS: begin
`ifdef ALARM_SET_EN
                    state_nx = ST_SET_AHRS;
`else
                    state_nx = ST_RUN;
`endif
                end
`ifdef ALARM_SET_EN
                ST_SET_AHRS: state_nx = ST_SET_AMINS;
`endif
                default:     state_nx = ST_RUN;
            endcase
        end else if (in_set) begin
            if (rise_up) begin
                fire         = 1'b1;
                up_active_nx = 1'b1;
                hold_nx      = '0;
            end else if (up_active && btn_up) begin
                if (hold_inc == HOLD_W'(HOLD_CYC)) begin
                    fire    = 1'b1;
                    hold_nx = HOLD_W'(RELOAD_CYC);
                end else begin
                    hold_nx = hold_inc;
                end
            end else begin
                up_active_nx = 1'b0;
                hold_nx      = '0;
            end
        end else begin
            up_active_nx = 1'b0;
            hold_nx      = '0;
        end

        // Inactivity timeout back to RUN
        if (!in_set || rise_mode || rise_up || fire) begin
            idle_nx = '0;
        end else if (idle_inc == IDLE_W'(TIMEOUT_CYC)) begin
            idle_nx      = '0;
            state_nx     = ST_RUN;
            up_active_nx = 1'b0;
            hold_nx      = '0;
        end else begin
            idle_nx = idle_inc;
        end

        // Route the increment to the field being edited
        if (fire) begin
            dirty_nx = 1'b1;
            case (state)
                ST_SET_HRS:   inc_hrs_nx      = 1'b1;
                ST_SET_MINS:  inc_mins_nx     = 1'b1;
`ifdef ALARM_SET_EN
                ST_SET_AHRS:  inc_alm_hrs_nx  = 1'b1;
                ST_SET_AMINS: inc_alm_mins_nx = 1'b1;
`endif
                default:      ;
            endcase
        end

        // Leaving a session: clear seconds only if something was changed
        if (in_set && (state_nx == ST_RUN)) begin
            clr_secs_nx = dirty;
            dirty_nx    = 1'b0;
        end

        // Blink phase: restart visible on field entry and on every increment
        if (state_nx == ST_RUN) begin
            blink_cnt_nx = '0;
            blink_ph_nx  = 1'b0;
        end else if ((state_nx != state) || fire) begin
            blink_cnt_nx = '0;
            blink_ph_nx  = 1'b0;
        end else if (blink_inc == BLINK_W'(BLINK_CYC)) begin
            blink_cnt_nx = '0;
            blink_ph_nx  = ~blink_ph;
        end else begin
            blink_cnt_nx = blink_inc;
        end

        // Outputs follow the next state so they change together with mode
        run_en_nx = (state_nx == ST_RUN);
        case (state_nx)
            ST_SET_HRS, ST_SET_AHRS:   blank_nx = {blink_ph_nx, blink_ph_nx, 2'b00};
            ST_SET_MINS, ST_SET_AMINS: blank_nx = {2'b00, blink_ph_nx, blink_ph_nx};
            default:                   blank_nx = 4'b0000;
        endcase
    end

    // Register bank
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state         <= ST_RUN;
            btn_mode_prev <= 1'b0;
            btn_up_prev   <= 1'b0;
            up_active     <= 1'b0;
            hold_cnt      <= '0;
            idle_cnt      <= '0;
            blink_cnt     <= '0;
            blink_ph      <= 1'b0;
            dirty         <= 1'b0;
            inc_hrs_p     <= 1'b0;
            inc_mins_p    <= 1'b0;
            clr_secs_p    <= 1'b0;
            run_en        <= 1'b1;
            blank_mask    <= 4'b0000;
        end else begin
            state         <= state_nx;
            btn_mode_prev <= btn_mode;
            btn_up_prev   <= btn_up;
            up_active     <= up_active_nx;
            hold_cnt      <= hold_nx;
            idle_cnt      <= idle_nx;
            blink_cnt     <= blink_cnt_nx;
            blink_ph      <= blink_ph_nx;
            dirty         <= dirty_nx;
            inc_hrs_p     <= inc_hrs_nx;
            inc_mins_p    <= inc_mins_nx;
            clr_secs_p    <= clr_secs_nx;
            run_en        <= run_en_nx;
            blank_mask    <= blank_nx;
        end
    end

`ifdef ALARM_SET_EN
    // Alarm field pulses
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            inc_alm_hrs_p  <= 1'b0;
            inc_alm_mins_p <= 1'b0;
        end else begin
            inc_alm_hrs_p  <= inc_alm_hrs_nx;
            inc_alm_mins_p <= inc_alm_mins_nx;
        end
    end
`else
    assign inc_alm_hrs_p  = 1'b0;
    assign inc_alm_mins_p = 1'b0;
`endif

endmodule
